decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 91 +++++++++
 rtl/decode_stage_if.sv | 37 +++
 rtl/decode_stage_instr_decode_comb.sv | 132 +++++++++++++
 rtl/decode_stage.sv | 79 +++++++
 tb/tb_decode_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32 decode stage: opcode constants, ALU/MDU
// operation codes, out_ctrl bit positions, reg_src codes and the decoded
// bundle carried from the combinational decoder into the stage register.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL    = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK   = 32'h0010_0073;
  localparam logic [31:0] INSTR_SELF_JAL = 32'h0000_006F;

  // Base ops occupy 0..9; the M extension maps to 16..23 = {2'b10, funct3}.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  // out_ctrl = {reg_wen, mem_wen, mem_ren, branch, jal, jalr, auipc, lui,
  //             src_b_reg, is_muldiv, reg_src[1:0]}
  localparam int CTRL_REG_WEN   = 11;
  localparam int CTRL_MEM_WEN   = 10;
  localparam int CTRL_MEM_REN   = 9;
  localparam int CTRL_BRANCH    = 8;
  localparam int CTRL_JAL       = 7;
  localparam int CTRL_JALR      = 6;
  localparam int CTRL_AUIPC     = 5;
  localparam int CTRL_LUI       = 4;
  localparam int CTRL_SRC_B_REG = 3;
  localparam int CTRL_IS_MULDIV = 2;
  localparam int CTRL_REG_SRC   = 0;  // lsb of the 2-bit field

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC4  = 2'b10,
    SRC_IMM  = 2'b11
  } reg_src_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [2:0]  funct3;
    logic [11:0] ctrl;
    logic        illegal;
    logic        ebreak;
  } decoded_t;

  // Register/immediate ALU op from funct3. alt selects SUB/SRA.
  function automatic logic [4:0] base_alu_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  base_alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  base_alu_op = ALU_SLL;
      3'b010:  base_alu_op = ALU_SLT;
      3'b011:  base_alu_op = ALU_SLTU;
      3'b100:  base_alu_op = ALU_XOR;
      3'b101:  base_alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_alu_op = ALU_OR;
      default: base_alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of all decode-stage signals other than clk/rst_n.
// slave  : the decode stage (consumes fetch/hazard/execute inputs)
// master : the environment (fetch, hazard unit, execute)
interface decode_stage_if #(parameter int CNT_W = 16) ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [31:0]       in_pc;
  logic              flush;
  logic              hz_load_valid;
  logic [4:0]        hz_load_rd;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic [31:0]       out_imm;
  logic [4:0]        out_alu_op;
  logic [2:0]        out_funct3;
  logic [11:0]       out_ctrl;
  logic              out_illegal;
  logic              out_ebreak;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, hz_load_valid, hz_load_rd, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_alu_op, out_funct3, out_ctrl, out_illegal, out_ebreak, stall_cnt
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, hz_load_valid, hz_load_rd, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
           out_alu_op, out_funct3, out_ctrl, out_illegal, out_ebreak, stall_cnt
  );
endinterface

// File: rtl/decode_stage_instr_decode_comb.sv
// Purely combinational RV32I(+M) decoder.
// instr    : raw instruction
// dec      : decoded bundle (fields, immediate, alu_op, ctrl, exception flags)
// uses_rs1 : instruction reads rs1 (all formats except U/J)
// uses_rs2 : instruction reads rs2 (R/S/B only)
module instr_decode_comb
  import decode_stage_pkg::*;
#(
  parameter bit M_EXT = 1'b1
) (
  input  logic [31:0] instr,
  output decoded_t    dec,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        writes_rd;
  logic        illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec        = '0;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    dec.funct3 = funct3;
    dec.alu_op = ALU_ADD;
    writes_rd  = 1'b0;
    illegal    = 1'b0;
    uses_rs1   = 1'b1;
    uses_rs2   = 1'b0;

    case (opcode)
      OPC_OP: begin
        writes_rd                 = 1'b1;
        uses_rs2                  = 1'b1;
        dec.ctrl[CTRL_SRC_B_REG]  = 1'b1;
        if (funct7 == 7'h00) begin
          dec.alu_op = base_alu_op(funct3, 1'b0);
        end else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.alu_op = base_alu_op(funct3, 1'b1);
        end else if (funct7 == 7'h01 && M_EXT) begin
          dec.ctrl[CTRL_IS_MULDIV] = 1'b1;
          dec.alu_op               = {2'b10, funct3};
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        writes_rd  = 1'b1;
        dec.imm    = imm_i;
        // instr[30] only distinguishes SRAI; for ADDI it is immediate data.
        dec.alu_op = base_alu_op(funct3, (funct3 == 3'b101) && instr[30]);
      end
      OPC_LOAD: begin
        writes_rd                = 1'b1;
        dec.imm                  = imm_i;
        dec.ctrl[CTRL_MEM_REN]   = 1'b1;
        dec.ctrl[CTRL_REG_SRC+:2] = SRC_LOAD;
      end
      OPC_STORE: begin
        uses_rs2               = 1'b1;
        dec.imm                = imm_s;
        dec.ctrl[CTRL_MEM_WEN] = 1'b1;
      end
      OPC_BRANCH: begin
        uses_rs2                 = 1'b1;
        dec.imm                  = imm_b;
        dec.ctrl[CTRL_BRANCH]    = 1'b1;
        dec.ctrl[CTRL_SRC_B_REG] = 1'b1;
        dec.alu_op               = funct3[1] ? ALU_SLTU : ALU_SLT;
      end
      OPC_JAL: begin
        writes_rd                 = 1'b1;
        uses_rs1                  = 1'b0;
        dec.imm                   = imm_j;
        dec.ctrl[CTRL_JAL]        = 1'b1;
        dec.ctrl[CTRL_REG_SRC+:2] = SRC_PC4;
      end
      OPC_JALR: begin
        writes_rd                 = 1'b1;
        dec.imm                   = imm_i;
        dec.ctrl[CTRL_JALR]       = 1'b1;
        dec.ctrl[CTRL_REG_SRC+:2] = SRC_PC4;
      end
      OPC_LUI: begin
        writes_rd                 = 1'b1;
        uses_rs1                  = 1'b0;
        dec.imm                   = imm_u;
        dec.ctrl[CTRL_LUI]        = 1'b1;
        dec.ctrl[CTRL_REG_SRC+:2] = SRC_IMM;
      end
      OPC_AUIPC: begin
        writes_rd           = 1'b1;
        uses_rs1            = 1'b0;
        dec.imm             = imm_u;
        dec.ctrl[CTRL_AUIPC] = 1'b1;
      end
      OPC_MISC_MEM: begin
        // FENCE: no architectural effect in this in-order pipeline.
        dec.imm = imm_i;
      end
      OPC_SYSTEM: begin
        dec.imm = imm_i;
        illegal = (instr != INSTR_ECALL) && (instr != INSTR_EBREAK);
      end
      default: illegal = 1'b1;
    endcase

    dec.illegal             = illegal;
    dec.ctrl[CTRL_REG_WEN]  = writes_rd && (dec.rd != 5'd0) && !illegal;
    if (illegal) begin
      dec.ctrl[CTRL_MEM_WEN] = 1'b0;
      dec.ctrl[CTRL_MEM_REN] = 1'b0;
    end
    // A jump-to-self can never make progress, so it is trapped like ebreak.
    dec.ebreak = (instr == INSTR_EBREAK) || (instr == INSTR_SELF_JAL);
  end

endmodule

// File: rtl/decode_stage.sv
// RV32 decode pipeline stage with a single output register.
// clk, rst_n : clock, asynchronous active-low reset
// bus        : fetch handshake (in_*), flush, load-use hazard inputs (hz_*),
//              execute handshake and decoded bundle (out_*), stall counter.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit M_EXT = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);

  decoded_t         dec;
  decoded_t         out_reg;
  logic [31:0]      pc_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             uses_rs1, uses_rs2;
  logic             hazard, in_ready, accept, stall;

  instr_decode_comb #(.M_EXT(M_EXT)) u_decode (
    .instr    (bus.in_instr),
    .dec      (dec),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign hazard = bus.hz_load_valid && (bus.hz_load_rd != 5'd0) &&
                  ((uses_rs1 && dec.rs1 == bus.hz_load_rd) ||
                   (uses_rs2 && dec.rs2 == bus.hz_load_rd));

  // Flush always drains the offered instruction; ready is forced low while
  // reset is asserted so every output reads 0.
  assign in_ready = rst_n && (bus.flush || ((!valid_reg || bus.out_ready) && !hazard));
  assign accept   = bus.in_valid && in_ready;
  assign stall    = bus.in_valid && !in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      out_reg   <= '0;
      pc_reg    <= '0;
    end else if (bus.flush) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg <= 1'b1;
      out_reg   <= dec;
      pc_reg    <= bus.in_pc;
    end else if (bus.out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (stall && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_reg;
  assign bus.out_pc      = pc_reg;
  assign bus.out_rs1     = out_reg.rs1;
  assign bus.out_rs2     = out_reg.rs2;
  assign bus.out_rd      = out_reg.rd;
  assign bus.out_imm     = out_reg.imm;
  assign bus.out_alu_op  = out_reg.alu_op;
  assign bus.out_funct3  = out_reg.funct3;
  assign bus.out_ctrl    = out_reg.ctrl;
  assign bus.out_illegal = out_reg.illegal;
  assign bus.out_ebreak  = out_reg.ebreak;
  assign bus.stall_cnt   = cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [2:0]  f3;
    logic [11:0] ctrl;
    logic        ill;
    logic        ebr;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  bundle_t exp_q[$];

  decode_stage_if #(.CNT_W(16)) bus ();
  decode_stage_if #(.CNT_W(16)) bus0 ();

  decode_stage #(.M_EXT(1'b1), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  decode_stage #(.M_EXT(1'b0), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  // Second instance (no M extension) sees identical stimulus.
  assign bus0.in_valid      = bus.in_valid;
  assign bus0.in_instr      = bus.in_instr;
  assign bus0.in_pc         = bus.in_pc;
  assign bus0.flush         = bus.flush;
  assign bus0.hz_load_valid = bus.hz_load_valid;
  assign bus0.hz_load_rd    = bus.hz_load_rd;
  assign bus0.out_ready     = bus.out_ready;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bundle_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] imm, input logic [4:0] alu,
                                 input logic [2:0] f3, input logic [11:0] ctrl, input logic ill,
                                 input logic ebr);
    bundle_t b;
    b.pc = pc; b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.imm = imm;
    b.alu = alu; b.f3 = f3; b.ctrl = ctrl; b.ill = ill; b.ebr = ebr;
    return b;
  endfunction

  // Monitor: every bundle handed to execute is compared with the scoreboard.
  always @(negedge clk) begin
    bundle_t got, e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got.pc = bus.out_pc; got.rs1 = bus.out_rs1; got.rs2 = bus.out_rs2; got.rd = bus.out_rd;
      got.imm = bus.out_imm; got.alu = bus.out_alu_op; got.f3 = bus.out_funct3;
      got.ctrl = bus.out_ctrl; got.ill = bus.out_illegal; got.ebr = bus.out_ebreak;
      if (exp_q.size() == 0) begin
        check("unexpected_bundle", 128'(got), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("bundle_pc%h", e.pc), 128'(got), 128'(e));
        $display("txn pc=%h rs1=%0d rs2=%0d rd=%0d imm=%h alu=%0d ctrl=%h ill=%b ebr=%b",
                 got.pc, got.rs1, got.rs2, got.rd, got.imm, got.alu, got.ctrl, got.ill, got.ebr);
        if (e.pc == 32'h104) begin
          check("mext0_mul_illegal", 128'(bus0.out_illegal), 128'(1));
          check("mext0_mul_reg_wen", 128'(bus0.out_ctrl[11]), 128'(0));
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input bundle_t e);
    logic acc;
    exp_q.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check($sformatf("accept_pc%h", pc), 128'(acc), 128'(1));
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_instr      = 32'h0;
    bus.in_pc         = 32'h0;
    bus.flush         = 1'b0;
    bus.hz_load_valid = 1'b0;
    bus.hz_load_rd    = 5'd0;
    bus.out_ready     = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_stall_cnt", 128'(bus.stall_cnt), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(0));
    check("rst_out_ctrl", 128'(bus.out_ctrl), 128'(0));
    check("rst_out_pc", 128'(bus.out_pc), 128'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed decode vectors
    send(32'h002081B3, 32'h100, mk(32'h100, 5'd1, 5'd2, 5'd3, 32'h0, 5'd0, 3'd0, 12'h808, 1'b0, 1'b0));
    send(32'h027302B3, 32'h104, mk(32'h104, 5'd6, 5'd7, 5'd5, 32'h0, 5'd16, 3'd0, 12'h80C, 1'b0, 1'b0));
    send(32'h00100073, 32'h108, mk(32'h108, 5'd0, 5'd1, 5'd0, 32'h1, 5'd0, 3'd0, 12'h000, 1'b0, 1'b1));
    send(32'hFFFFFFFF, 32'h10C, mk(32'h10C, 5'd31, 5'd31, 5'd31, 32'h0, 5'd0, 3'd7, 12'h000, 1'b1, 1'b0));
    send(32'h00812203, 32'h110, mk(32'h110, 5'd2, 5'd8, 5'd4, 32'h8, 5'd0, 3'd2, 12'hA01, 1'b0, 1'b0));
    send(32'hFE20EEE3, 32'h114, mk(32'h114, 5'd1, 5'd2, 5'd29, 32'hFFFFFFFC, 5'd4, 3'd6, 12'h108, 1'b0, 1'b0));
    send(32'h0000006F, 32'h118, mk(32'h118, 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 3'd0, 12'h082, 1'b0, 1'b1));
    send(32'h123453B7, 32'h11C, mk(32'h11C, 5'd8, 5'd3, 5'd7, 32'h12345000, 5'd0, 3'd5, 12'h813, 1'b0, 1'b0));

    // Load-use hazard on rs1 = x5 for three cycles
    bus.hz_load_valid = 1'b1;
    bus.hz_load_rd    = 5'd5;
    bus.in_valid      = 1'b1;
    bus.in_instr      = 32'h00028333;
    bus.in_pc         = 32'h200;
    exp_q.push_back(mk(32'h200, 5'd5, 5'd0, 5'd6, 32'h0, 5'd0, 3'd0, 12'h808, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hz_in_ready_%0d", i), 128'(bus.in_ready), 128'(0));
      if (i == 1) check("hz_bubble", 128'(bus.out_valid), 128'(0));
      @(posedge clk); #1;
    end
    check("hz_stall_cnt", 128'(bus.stall_cnt), 128'(3));
    bus.hz_load_valid = 1'b0;
    @(negedge clk);
    check("hz_release_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure for four cycles, then flush
    bus.out_ready = 1'b0;
    send(32'hFE20EEE3, 32'h300, mk(32'h300, 5'd1, 5'd2, 5'd29, 32'hFFFFFFFC, 5'd4, 3'd6, 12'h108, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hFFFFFFFF;
    bus.in_pc    = 32'h304;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", i), 128'(bus.in_ready), 128'(0));
      check($sformatf("bp_hold_%0d", i), 128'({bus.out_valid, bus.out_pc, bus.out_imm, bus.out_ctrl}),
            128'({1'b1, 32'h300, 32'hFFFFFFFC, 12'h108}));
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 128'(bus.out_valid), 128'(0));
    check("bp_stall_cnt", 128'(bus.stall_cnt), 128'(7));
    void'(exp_q.pop_back());  // held bundle was flushed, never consumed
    @(posedge clk); #1;

    // Reset pulse in the middle of a stall
    send(32'h002081B3, 32'h400, mk(32'h400, 5'd1, 5'd2, 5'd3, 32'h0, 5'd0, 3'd0, 12'h808, 1'b0, 1'b0));
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00812203;
    bus.in_pc    = 32'h404;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_stall_cnt", 128'(bus.stall_cnt), 128'(9));
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("async_rst_stall_cnt", 128'(bus.stall_cnt), 128'(0));
    void'(exp_q.pop_back());  // held bundle dropped by reset
    @(posedge clk); #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back(mk(32'h404, 5'd2, 5'd8, 5'd4, 32'h8, 5'd0, 3'd2, 12'hA01, 1'b0, 1'b0));
    @(negedge clk);
    check("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
